// File: rtl/seq_shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module      : seq_shift_add_mult
// Description : Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
//               A load edge latches the operands, followed by exactly WIDTH
//               step edges. The product is valid while READY is high, and
//               DONE pulses for one cycle on completion. SIGNED_MODE selects
//               two's-complement operands. RESTART_EN selects what a START
//               during an operation does: reload, or be ignored.
// Ports       : CK          - clock, rising edge
//               RST         - synchronous active-high reset
//               START       - load request, sampled every rising edge
//               SIGNED_MODE - 1 = signed operands (latched at load)
//               A, B        - multiplicand / multiplier (latched at load)
//               P           - product register (valid while READY=1)
//               READY       - idle, result valid
//               BUSY        - operation in progress (~READY)
//               DONE        - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module seq_shift_add_mult #(
    parameter int WIDTH      = 4,
    parameter bit RESTART_EN = 1'b1
) (
    input  logic                 CK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 SIGNED_MODE,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   P,
    output logic                 READY,
    output logic                 BUSY,
    output logic                 DONE
);

    localparam int                 c_CNT_W     = $clog2(WIDTH + 1);
    localparam logic [0:0]         c_ST_IDLE   = 1'b0;
    localparam logic [0:0]         c_ST_RUN    = 1'b1;
    localparam logic [c_CNT_W-1:0] c_LAST_STEP = c_CNT_W'(WIDTH - 1);

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_areg;
    logic               r_mode;
    logic [2*WIDTH-1:0] r_p;
    logic               r_done;

    logic               w_load;
    logic               w_step;
    logic               w_last;
    logic [WIDTH-1:0]   w_h;
    logic [WIDTH:0]     w_h_ext;
    logic [WIDTH:0]     w_a_ext;
    logic [WIDTH:0]     w_addend;
    logic [WIDTH:0]     w_sum;

    // A START in RUN only wins when restarts are enabled.
    assign w_load = START && ((r_state == c_ST_IDLE) || RESTART_EN);
    assign w_step = (r_state == c_ST_RUN) && !w_load;
    assign w_last = (r_cnt == c_LAST_STEP);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CK) begin
        if (RST) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_load) begin
            w_state_nxt = c_ST_RUN;
        end else if (w_step && w_last) begin
            w_state_nxt = c_ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: one W+1-bit add per step. In signed mode the multiplier's
    // MSB carries weight -2^(W-1), so the last partial product is
    // subtracted instead of added. The extra sum bit keeps the carry
    // (unsigned) or the correct sign (signed) when it is shifted into P.
    // ------------------------------------------------------------------
    assign w_h      = r_p[2*WIDTH-1:WIDTH];
    assign w_h_ext  = {r_mode & w_h[WIDTH-1], w_h};
    assign w_a_ext  = {r_mode & r_areg[WIDTH-1], r_areg};
    assign w_addend = r_p[0] ? w_a_ext : '0;
    assign w_sum    = (r_mode && w_last) ? (w_h_ext - w_addend)
                                         : (w_h_ext + w_addend);

    always_ff @(posedge CK) begin
        if (RST) begin
            r_p    <= '0;
            r_cnt  <= '0;
            r_areg <= '0;
            r_mode <= 1'b0;
            r_done <= 1'b0;
        end else begin
            // A load always suppresses DONE, including an aborted operation.
            r_done <= w_step && w_last;
            if (w_load) begin
                r_areg <= A;
                r_mode <= SIGNED_MODE;
                r_p    <= {{WIDTH{1'b0}}, B};
                r_cnt  <= '0;
            end else if (w_step) begin
                r_p    <= {w_sum, r_p[WIDTH-1:1]};
                r_cnt  <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign P     = r_p;
    assign READY = (r_state == c_ST_IDLE);
    assign BUSY  = (r_state == c_ST_RUN);
    assign DONE  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_shift_add_mult
// Description : Scoreboard bench for seq_shift_add_mult. Three instances:
//               WIDTH=4 with restart, WIDTH=4 without restart (both share
//               stimulus), and WIDTH=8. Expected products are queued when an
//               operation is issued; monitors pop them on every DONE pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_shift_add_mult;

    logic clk;
    logic rst;

    // shared stimulus for the two WIDTH=4 instances
    logic       s4_start;
    logic       s4_mode;
    logic [3:0] s4_a;
    logic [3:0] s4_b;
    logic [7:0] p4r, p4n;
    logic       ready4r, busy4r, done4r;
    logic       ready4n, busy4n, done4n;

    logic        s8_start;
    logic        s8_mode;
    logic [7:0]  s8_a;
    logic [7:0]  s8_b;
    logic [15:0] p8;
    logic        ready8, busy8, done8;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  q4r[$];
    logic [7:0]  q4n[$];
    logic [15:0] q8[$];

    seq_shift_add_mult #(.WIDTH(4), .RESTART_EN(1'b1)) u_dut4r (
        .CK(clk), .RST(rst), .START(s4_start), .SIGNED_MODE(s4_mode),
        .A(s4_a), .B(s4_b), .P(p4r), .READY(ready4r), .BUSY(busy4r),
        .DONE(done4r)
    );

    seq_shift_add_mult #(.WIDTH(4), .RESTART_EN(1'b0)) u_dut4n (
        .CK(clk), .RST(rst), .START(s4_start), .SIGNED_MODE(s4_mode),
        .A(s4_a), .B(s4_b), .P(p4n), .READY(ready4n), .BUSY(busy4n),
        .DONE(done4n)
    );

    seq_shift_add_mult #(.WIDTH(8), .RESTART_EN(1'b1)) u_dut8 (
        .CK(clk), .RST(rst), .START(s8_start), .SIGNED_MODE(s8_mode),
        .A(s8_a), .B(s8_b), .P(p8), .READY(ready8), .BUSY(busy8),
        .DONE(done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (done4r) begin
            if (q4r.size() == 0) chk("unexpected_done_4r", 1, 0);
            else chk("p_4r", p4r, q4r.pop_front());
        end
        if (done4n) begin
            if (q4n.size() == 0) chk("unexpected_done_4n", 1, 0);
            else chk("p_4n", p4n, q4n.pop_front());
        end
        if (done8) begin
            if (q8.size() == 0) chk("unexpected_done_8", 1, 0);
            else chk("p_8", p8, q8.pop_front());
        end
    end

    // ---------------- stimulus helpers ----------------
    // Timed WIDTH=4 operation: checks READY/DONE/BUSY cycle by cycle.
    task automatic op4_timed(input logic [3:0] a, input logic [3:0] b,
                             input logic m, input logic [7:0] exp);
        q4r.push_back(exp);
        q4n.push_back(exp);
        s4_a = a; s4_b = b; s4_mode = m; s4_start = 1'b1;
        @(negedge clk);                       // load edge passed
        s4_start = 1'b0;
        s4_a = ~a; s4_b = ~b; s4_mode = ~m;   // don't-care during RUN
        for (int i = 0; i < 4; i++) begin
            chk("busy_ready4r", ready4r, 0);
            chk("busy_ready4n", ready4n, 0);
            chk("busy_done4r", done4r, 0);
            @(negedge clk);
        end
        chk("done4r_pulse", done4r, 1);
        chk("done4n_pulse", done4n, 1);
        chk("ready4r_end", ready4r, 1);
        chk("busy4r_end", busy4r, 0);
        @(negedge clk);
        chk("done4r_clear", done4r, 0);
        chk("done4n_clear", done4n, 0);
        chk("ready4r_hold", ready4r, 1);
    endtask

    // Fast WIDTH=4 operation: returns at the DONE cycle so the next call
    // issues START back-to-back.
    task automatic op4_fast(input logic [3:0] a, input logic [3:0] b, input logic m);
        logic [7:0] ea, eb, e;
        int n;
        ea = m ? {{4{a[3]}}, a} : {4'b0, a};
        eb = m ? {{4{b[3]}}, b} : {4'b0, b};
        e  = ea * eb;
        q4r.push_back(e);
        q4n.push_back(e);
        s4_a = a; s4_b = b; s4_mode = m; s4_start = 1'b1;
        @(negedge clk);
        s4_start = 1'b0;
        n = 0;
        while (!ready4r && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk("lat4", n, 4);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic m);
        logic [15:0] ea, eb, e;
        int n;
        ea = m ? {{8{a[7]}}, a} : {8'b0, a};
        eb = m ? {{8{b[7]}}, b} : {8'b0, b};
        e  = ea * eb;
        q8.push_back(e);
        s8_a = a; s8_b = b; s8_mode = m; s8_start = 1'b1;
        @(negedge clk);
        s8_start = 1'b0;
        n = 0;
        while (!ready8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("lat8", n, 8);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        s4_start = 0; s4_mode = 0; s4_a = 0; s4_b = 0;
        s8_start = 0; s8_mode = 0; s8_a = 0; s8_b = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_p4r", p4r, 0);
        chk("rst_ready4r", ready4r, 1);
        chk("rst_busy4r", busy4r, 0);
        chk("rst_done4r", done4r, 0);
        chk("rst_p8", p8, 0);
        chk("rst_ready8", ready8, 1);

        // hand-computed WIDTH=4 vectors
        op4_timed(4'd15, 4'd15, 1'b0, 8'hE1);
        op4_timed(4'h8,  4'h7,  1'b1, 8'hC8);
        op4_timed(4'h8,  4'h8,  1'b1, 8'h40);
        op4_timed(4'h7,  4'hF,  1'b1, 8'hF9);

        // START during RUN: restart instance aborts, other ignores it
        q4r.push_back(8'd42);
        q4n.push_back(8'd15);
        s4_a = 4'd3; s4_b = 4'd5; s4_mode = 0; s4_start = 1;
        @(negedge clk);             // load edge L
        s4_start = 0;
        @(negedge clk);             // L+1
        s4_a = 4'd6; s4_b = 4'd7; s4_start = 1;
        @(negedge clk);             // L+2: restart / ignored
        s4_start = 0; s4_a = 0; s4_b = 0;
        @(negedge clk);             // L+3
        @(negedge clk);             // L+4
        chk("norestart_done", done4n, 1);
        chk("restart_no_early_done", done4r, 0);
        @(negedge clk);             // L+5
        chk("restart_still_busy", ready4r, 0);
        chk("norestart_done_clear", done4n, 0);
        @(negedge clk);             // L+6
        chk("restart_done", done4r, 1);
        @(negedge clk);

        // reset mid-operation
        s4_a = 4'd5; s4_b = 4'd5; s4_start = 1;
        @(negedge clk);
        s4_start = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("midrst_p4r", p4r, 0);
        chk("midrst_ready4r", ready4r, 1);
        chk("midrst_done4r", done4r, 0);
        chk("midrst_p4n", p4n, 0);
        chk("midrst_busy4n", busy4n, 0);
        repeat (6) @(negedge clk);
        op4_timed(4'd2, 4'd3, 1'b0, 8'd6);

        // exhaustive WIDTH=4, back-to-back
        for (int m = 0; m < 2; m++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    op4_fast(4'(a), 4'(b), m[0]);

        // WIDTH=8 directed corners, then random vectors in both modes
        op8(8'hFF, 8'hFF, 1'b0);
        op8(8'h80, 8'h80, 1'b1);
        op8(8'hFF, 8'h80, 1'b1);
        op8(8'h80, 8'h02, 1'b0);
        op8(8'h00, 8'h9C, 1'b1);
        for (int i = 0; i < 120; i++)
            op8(8'($urandom), 8'($urandom), i[0]);

        repeat (12) @(negedge clk);
        chk("q4r_drained", q4r.size(), 0);
        chk("q4n_drained", q4n.size(), 0);
        chk("q8_drained", q8.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
